bus_rr_arbit: RTL

BUS_RR_ARBIT -- requirements
Module: bus_rr_arbit

---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_rr_pick.sv | 40 ++++
 rtl/bus_rr_arbit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg
// Shared definitions for the bus blocks: the default master count, the
// default per-grant hold limit and the arbiter FSM state encoding.
package bus_pkg;

    localparam int NUM_M    = 4;
    localparam int MAX_HOLD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } bus_state_t;

endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick
// Combinational round-robin selector. Starting one position after
// last_owner and wrapping modulo NUM_M, returns the first asserted
// request bit.
// Ports:
//   req        - request vector, one bit per master
//   last_owner - index of the most recent owner (search starts after it)
//   valid      - high when any request bit is set
//   index      - index of the selected master (0 when valid is low)
module bus_rr_pick #(
    parameter  int NUM_M = 4,
    localparam int ID_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [ID_W-1:0]  last_owner,
    output logic             valid,
    output logic [ID_W-1:0]  index
);

    int              j;
    logic [ID_W-1:0] jx;

    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        jx    = '0;
        // Offsets 1..NUM_M visit every master once; last_owner itself is
        // checked last so it only wins when nobody else is asking.
        for (int i = 1; i <= NUM_M; i++) begin
            j  = (int'(last_owner) + i) % NUM_M;
            jx = ID_W'(j);
            if (!valid && req[jx]) begin
                valid = 1'b1;
                index = jx;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbit.sv
// bus_rr_arbit
// Round-robin bus arbiter with a bounded hold time. A granted master owns
// the bus until it pulses m_done, drops its request, or reaches MAX_HOLD
// cycles of ownership. Every release is followed by a one-cycle GAP with
// no grant before the next owner is selected.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset_n  - synchronous active-low reset
//   m_req    - per-master level request
//   m_done   - per-master end-of-transfer pulse (only the owner's bit counts)
//   m_grant  - registered one-hot grant, or all-zero
//   grant_id - index of current owner, 0 when no grant
//   bus_busy - high exactly when m_grant is nonzero
//   timeout  - one-cycle pulse in the GAP after a forced release
module bus_rr_arbit #(
    parameter  int NUM_M    = bus_pkg::NUM_M,
    parameter  int MAX_HOLD = bus_pkg::MAX_HOLD,
    localparam int ID_W     = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    localparam int HC_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] m_req,
    input  logic [NUM_M-1:0] m_done,
    output logic [NUM_M-1:0] m_grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             bus_busy,
    output logic             timeout
);

    import bus_pkg::*;

    bus_state_t       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [HC_W-1:0]  hold_q, hold_d;

    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic             own_req;
    logic             own_done;
    logic             at_max;

    bus_rr_pick #(
        .NUM_M (NUM_M)
    ) u_pick (
        .req        (m_req),
        .last_owner (last_q),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    // Only the owner's request/done bits matter while in OWN.
    assign own_req  = m_req[id_q];
    assign own_done = m_done[id_q];
    assign at_max   = (hold_q == HC_W'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        grant_d = '0;
        id_d    = '0;
        busy_d  = 1'b0;
        to_d    = 1'b0;
        last_d  = last_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE, GAP: begin
                hold_d = '0;
                if (pick_valid) begin
                    state_d           = OWN;
                    grant_d[pick_idx] = 1'b1;
                    id_d              = pick_idx;
                    busy_d            = 1'b1;
                    last_d            = pick_idx;
                end else begin
                    state_d = IDLE;
                end
            end

            OWN: begin
                if (own_done || !own_req || at_max) begin
                    state_d = GAP;
                    hold_d  = '0;
                    // Timeout flags only a forced release: the master still
                    // wanted the bus and had not finished.
                    to_d    = at_max && own_req && !own_done;
                end else begin
                    grant_d = grant_q;
                    id_d    = id_q;
                    busy_d  = 1'b1;
                    hold_d  = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            // Start as if the last master owned the bus so M0 wins first.
            last_q  <= ID_W'(NUM_M - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign m_grant  = grant_q;
    assign grant_id = id_q;
    assign bus_busy = busy_q;
    assign timeout  = to_q;

endmodule
